// File: rtl/regfile_wb_arbiter.sv
// Write-port arbiter sharing the regfile write port between the WB stage and the MDU.
// Build option REGFILE_ARB_STARVE_GUARD_EN adds the MDU starvation guard (counter + FORCE_MD).
module regfile_wb_arbiter #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_rd,
  input  logic [DW-1:0] wb_data,
  output logic          wb_ready,
  input  logic          md_valid,
  input  logic [AW-1:0] md_rd,
  input  logic [DW-1:0] md_data,
  output logic          md_ready,
  output logic          regwrite,
  output logic [AW-1:0] rd,
  output logic [DW-1:0] write_data,
  output logic          grant_md
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
    $error("regfile_wb_arbiter: STARVE_MAX must be in 1..15");
  end

  logic          wb_xfer;
  logic          md_xfer;
  logic          regwrite_q, regwrite_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [DW-1:0] write_data_q, write_data_d;
  logic          grant_md_q, grant_md_d;

  assign wb_xfer = wb_valid && wb_ready;
  assign md_xfer = md_valid && md_ready;

`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam logic [0:0] ST_NORMAL   = 1'b0;
  localparam logic [0:0] ST_FORCE_MD = 1'b1;
  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  logic [0:0] state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       md_denied;

  always_comb begin
    wb_ready = 1'b0;
    md_ready = 1'b0;
    if (!rst) begin
      if (state_q == ST_FORCE_MD) begin
        md_ready = 1'b1;
      end else begin
        wb_ready = 1'b1;
        md_ready = !wb_valid;
      end
    end
  end

  assign md_denied = md_valid && !md_ready;

  // Counter only grows while the MDU is actually waiting; any transfer or idle cycle restarts it.
  always_comb begin
    state_d  = state_q;
    starve_d = md_denied ? starve_q + 4'd1 : 4'd0;
    case (state_q)
      ST_NORMAL: begin
        if (md_denied && (starve_q + 4'd1 == STARVE_LIMIT)) begin
          state_d = ST_FORCE_MD;
        end
      end
      ST_FORCE_MD: begin
        if (md_xfer || !md_valid) begin
          state_d = ST_NORMAL;
        end
      end
      default: state_d = ST_NORMAL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_NORMAL;
      starve_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end
`else
  always_comb begin
    wb_ready = !rst;
    md_ready = !rst && !wb_valid;
  end
`endif

  // r0 writes are accepted and still update rd/write_data, but never raise regwrite.
  always_comb begin
    regwrite_d   = 1'b0;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    grant_md_d   = grant_md_q;
    if (wb_xfer) begin
      regwrite_d   = (wb_rd != '0);
      rd_d         = wb_rd;
      write_data_d = wb_data;
      grant_md_d   = 1'b0;
    end else if (md_xfer) begin
      regwrite_d   = (md_rd != '0);
      rd_d         = md_rd;
      write_data_d = md_data;
      grant_md_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_q   <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
      grant_md_q   <= 1'b0;
    end else begin
      regwrite_q   <= regwrite_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
      grant_md_q   <= grant_md_d;
    end
  end

  assign regwrite   = regwrite_q;
  assign rd         = rd_q;
  assign write_data = write_data_q;
  assign grant_md   = grant_md_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: cycle-level behavioural model plus directed literal checks.
// Honors REGFILE_ARB_STARVE_GUARD_EN to pick the expected arbitration policy.
module tb_regfile_wb_arbiter;
  localparam int STARVE_MAX = 4;
`ifdef REGFILE_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, md_valid;
  logic [4:0]  wb_rd, md_rd;
  logic [31:0] wb_data, md_data;
  logic        wb_ready, md_ready, regwrite, grant_md;
  logic [4:0]  rd;
  logic [31:0] write_data;

  int n_vec = 0;
  int n_err = 0;

  regfile_wb_arbiter #(.DW(32), .AW(5), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .wb_ready(wb_ready),
    .md_valid(md_valid), .md_rd(md_rd), .md_data(md_data), .md_ready(md_ready),
    .regwrite(regwrite), .rd(rd), .write_data(write_data), .grant_md(grant_md)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Regfile stand-in fed by the arbiter's write port.
  logic [31:0] rf_dut [32] = '{default: 32'd0};
  always @(posedge clk) begin
    if (!rst && regwrite) rf_dut[rd] <= write_data;
  end

  // Model: MDU is forced once it has waited STARVE_MAX consecutive denied cycles.
  int          md_wait;
  logic        exp_we, exp_gmd;
  logic [4:0]  exp_rd;
  logic [31:0] exp_data;
  logic        forced, exp_wb_ready, exp_md_ready;

  always_comb begin
    forced       = GUARD && (md_wait >= STARVE_MAX);
    exp_wb_ready = !rst && !forced;
    exp_md_ready = !rst && (forced || !wb_valid);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      md_wait  <= 0;
      exp_we   <= 1'b0;
      exp_rd   <= 5'd0;
      exp_data <= 32'd0;
      exp_gmd  <= 1'b0;
    end else begin
      exp_we <= 1'b0;
      if (wb_valid && exp_wb_ready) begin
        exp_we <= (wb_rd != 5'd0); exp_rd <= wb_rd; exp_data <= wb_data; exp_gmd <= 1'b0;
      end else if (md_valid && exp_md_ready) begin
        exp_we <= (md_rd != 5'd0); exp_rd <= md_rd; exp_data <= md_data; exp_gmd <= 1'b1;
      end
      md_wait <= (md_valid && !exp_md_ready) ? md_wait + 1 : 0;
    end
  end

  always @(negedge clk) begin
    chk("wb_ready", wb_ready, exp_wb_ready);
    chk("md_ready", md_ready, exp_md_ready);
    chk("regwrite", regwrite, exp_we);
    chk("rd", rd, exp_rd);
    chk("write_data", write_data, exp_data);
    chk("grant_md", grant_md, exp_gmd);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk); #1;
  endtask

  initial begin
    logic [31:0] wb_pat;
    logic [31:0] md_pat;
    logic        wb_acc, md_acc;
    rst = 1'b1;
    wb_valid = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();

    // Reset asserted mid-stream while WB holds a request
    wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'd123;
    step();
    rst = 1'b1;
    mid();
    chk("rst_wb_ready", wb_ready, 0);
    chk("rst_md_ready", md_ready, 0);
    chk("rst_regwrite", regwrite, 0);
    chk("rst_rd", rd, 0);
    chk("rst_write_data", write_data, 0);
    chk("rst_grant_md", grant_md, 0);
    step();
    rst = 1'b0;
    mid();
    chk("rel_wb_ready", wb_ready, 1);
    chk("rel_regwrite", regwrite, 0);
    step();
    wb_valid = 1'b0;
    chk("wb3_regwrite", regwrite, 1);
    chk("wb3_rd", rd, 3);
    chk("wb3_data", write_data, 123);
    chk("wb3_grant_md", grant_md, 0);
    step();
    chk("wb3_rf", rf_dut[3], 123);
    chk("wb3_regwrite_pulse", regwrite, 0);

    // WB vs MDU contention from cycle 0
    wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'd777;
    md_valid = 1'b1; md_rd = 5'd5; md_data = 32'd456;
`ifdef REGFILE_ARB_STARVE_GUARD_EN
    for (int k = 0; k < 5; k++) begin
      mid();
      chk("cont_wb_ready", wb_ready, (k < 4) ? 1 : 0);
      chk("cont_md_ready", md_ready, (k < 4) ? 0 : 1);
      step();
    end
    md_valid = 1'b0;
    chk("force_regwrite", regwrite, 1);
    chk("force_rd", rd, 5);
    chk("force_data", write_data, 456);
    chk("force_grant_md", grant_md, 1);
    chk("force_wb_resume", wb_ready, 1);
    step();
    chk("wb_resume_rd", rd, 9);
    chk("wb_resume_grant", grant_md, 0);
`else
    for (int k = 0; k < 20; k++) begin
      mid();
      chk("starve_md_ready", md_ready, 0);
      chk("starve_grant_md", grant_md, 0);
      step();
    end
    wb_valid = 1'b0;
    mid();
    chk("drain_md_ready", md_ready, 1);
    step();
    md_valid = 1'b0;
    chk("drain_rd", rd, 5);
    chk("drain_grant_md", grant_md, 1);
`endif
    wb_valid = 1'b0;
    step();
    chk("rf5", rf_dut[5], 456);

    // r0 write is accepted but never committed
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'd77;
    mid();
    chk("r0_wb_ready", wb_ready, 1);
    step();
    wb_valid = 1'b0;
    chk("r0_regwrite", regwrite, 0);
    chk("r0_rd", rd, 0);
    chk("r0_data", write_data, 77);
    step();
    chk("r0_rf", rf_dut[0], 0);

    // MDU alone is accepted in the same cycle
    md_valid = 1'b1; md_rd = 5'd7; md_data = 32'd9;
    mid();
    chk("mdu_md_ready", md_ready, 1);
    step();
    md_valid = 1'b0;
    chk("mdu_regwrite", regwrite, 1);
    chk("mdu_rd", rd, 7);
    chk("mdu_data", write_data, 9);
    chk("mdu_grant_md", grant_md, 1);
`ifdef REGFILE_ARB_STARVE_GUARD_EN
    chk("mdu_starve_cnt", dut.starve_q, 0);
`endif
    step();

    // Mixed traffic pattern, requests held until accepted
    wb_pat = 32'hFFF7_BFFE;
    md_pat = 32'h0FFF_80F6;
    wb_acc = 1'b1; md_acc = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (!(wb_valid && !wb_acc)) begin
        wb_valid = wb_pat[i]; wb_rd = 5'(i); wb_data = 32'hA000 + 32'(i);
      end
      if (!(md_valid && !md_acc)) begin
        md_valid = md_pat[i]; md_rd = 5'((i * 3 + 1) % 32); md_data = 32'hB000 + 32'(i);
      end
      @(negedge clk);
      wb_acc = wb_valid && exp_wb_ready;
      md_acc = md_valid && exp_md_ready;
      step();
    end
    wb_valid = 1'b0;
    for (int i = 0; i < 8 && md_valid; i++) begin
      @(negedge clk);
      md_acc = exp_md_ready;
      step();
      if (md_acc) md_valid = 1'b0;
    end
    md_valid = 1'b0;
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
